multicycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle RV32I core. Decodes the latched instruction opcode and

---
 rtl/multicycle_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences FETCH/DECODE/EXECUTE/MEM/WB
// over the shared datapath and owns the single memory port handshake with a wait timeout.
module multicycle_ctrl #(
  parameter int unsigned TMO_W   = 4,
  parameter int unsigned TMO_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_cond,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       bus_err
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_TRAP  = 2'd2;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_RTYP = 2'b10;
  localparam logic [1:0] ALU_ITYP = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_LD_WB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  state_t             state, state_next;
  logic [TMO_W-1:0]   cnt, cnt_next;
  logic               in_mem;
  logic               tmo;
  logic               req_raw;
  logic               we_raw;

  // State and wait-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign in_mem = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign tmo    = in_mem && !mem_ready && (cnt == TMO_W'(TMO_MAX));

  // Next state and datapath controls
  always_comb begin
    state_next = state;
    req_raw    = 1'b0;
    we_raw     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_PLUS4;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    aluop      = ALU_ADD;
    reg_we     = 1'b0;
    wb_sel     = 2'd0;
    illegal    = 1'b0;
    bus_err    = 1'b0;

    unique case (state)
      S_FETCH: begin
        req_raw = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd1;
        unique case (opcode)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          OP_JAL:             state_next = S_JAL;
          default:            state_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a  = 1'b1;
        aluop      = ALU_RTYP;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd1;
        aluop      = ALU_ITYP;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd1;
        state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        req_raw = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = S_LD_WB;
      end
      S_MEM_WR: begin
        req_raw = 1'b1;
        we_raw  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_LD_WB: begin
        reg_we     = 1'b1;
        wb_sel     = 2'd1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        aluop      = ALU_SUB;
        pc_src     = PC_ALU;
        pc_we      = br_cond;
        state_next = S_FETCH;
      end
      S_JAL: begin
        pc_we      = 1'b1;
        pc_src     = PC_ALU;
        reg_we     = 1'b1;
        wb_sel     = 2'd2;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        pc_we      = 1'b1;
        pc_src     = PC_TRAP;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // Wait timeout overrides the access: vector to trap handler, refetch
    if (tmo) begin
      bus_err    = 1'b1;
      pc_we      = 1'b1;
      pc_src     = PC_TRAP;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      state_next = S_FETCH;
    end
  end

  // Counter restarts on any state change, completion or timeout; counts only while waiting
  always_comb begin
    cnt_next = cnt;
    if ((in_mem && mem_ready) || tmo || (state_next != state)) cnt_next = '0;
    else if (req_raw)                                         cnt_next = cnt + TMO_W'(1);
  end

  // Reset kills an in-flight request immediately, without waiting for a clock edge
  assign mem_req = req_raw & rst_n;
  assign mem_we  = we_raw & rst_n;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: per-cycle expected control words, hand-derived
// from the state sequence of each instruction class, timeout and async reset.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       br_cond;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b, aluop;
  logic       reg_we;
  logic [1:0] wb_sel;
  logic       illegal, bus_err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       req, we, iord, ir, pcwe;
    logic [1:0] pcsrc;
    logic       a;
    logic [1:0] b, op;
    logic       rwe;
    logic [1:0] wb;
    logic       ill, berr;
  } ctl_t;

  ctl_t obs;
  assign obs = '{mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                 aluop, reg_we, wb_sel, illegal, bus_err};

  multicycle_ctrl #(.TMO_W(4), .TMO_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_cond(br_cond), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic ctl_t mk(input logic req, we, io, ir, pcwe, input logic [1:0] pcsrc,
                              input logic a, input logic [1:0] b, op, input logic rwe,
                              input logic [1:0] wb, input logic ill, berr);
    return '{req, we, io, ir, pcwe, pcsrc, a, b, op, rwe, wb, ill, berr};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  ctl_t IDLE, F_WAIT, F_RDY, F_TMO, DEC, EXR, EXI, AWB, MADDR, MRD, MWR, MWR_TMO, LWB,
        BR_T, BR_N, JALV, TRAPV;

  // One cycle: drive inputs, check the control word, advance to next clock
  task automatic cyc(input string tag, input logic mr, input logic bc, input ctl_t exp);
    mem_ready = mr;
    br_cond   = bc;
    #1;
    check(tag, 32'(obs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            req we io ir pcwe pcsrc a  b  op  rwe wb ill berr
    IDLE    = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
    F_WAIT  = mk(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
    F_RDY   = mk(1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
    F_TMO   = mk(1, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0, 2'd0, 0, 1);
    DEC     = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0, 2'd0, 0, 0);
    EXR     = mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd2, 0, 2'd0, 0, 0);
    EXI     = mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd3, 0, 2'd0, 0, 0);
    AWB     = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd0, 0, 0);
    MADDR   = mk(0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0, 2'd0, 0, 0);
    MRD     = mk(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
    MWR     = mk(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
    MWR_TMO = mk(1, 1, 1, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0, 2'd0, 0, 1);
    LWB     = mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 2'd1, 0, 0);
    BR_T    = mk(0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 2'd1, 0, 2'd0, 0, 0);
    BR_N    = mk(0, 0, 0, 0, 0, 2'd1, 1, 2'd0, 2'd1, 0, 2'd0, 0, 0);
    JALV    = mk(0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 1, 2'd2, 0, 0);
    TRAPV   = mk(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0, 2'd0, 1, 0);

    rst_n = 1'b0; mem_ready = 1'b0; br_cond = 1'b0; opcode = 7'b0110011;
    #1;
    check("in_reset", 32'(obs), 32'(IDLE));
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // add: 4 cycles
    opcode = 7'b0110011;
    cyc("add_fetch", 1, 0, F_RDY);
    cyc("add_dec", 0, 0, DEC);
    cyc("add_exec", 0, 0, EXR);
    cyc("add_wb", 0, 0, AWB);

    // lw with 3 wait cycles in MEM_RD
    opcode = 7'b0000011;
    cyc("lw_fetch", 1, 0, F_RDY);
    cyc("lw_dec", 0, 0, DEC);
    cyc("lw_addr", 0, 0, MADDR);
    for (int i = 0; i < 3; i++) cyc("lw_memwait", 0, 0, MRD);
    cyc("lw_memrdy", 1, 0, MRD);
    cyc("lw_wb", 0, 0, LWB);

    // sw with 2 wait cycles
    opcode = 7'b0100011;
    cyc("sw_fetch", 1, 0, F_RDY);
    cyc("sw_dec", 0, 0, DEC);
    cyc("sw_addr", 0, 0, MADDR);
    cyc("sw_wait", 0, 0, MWR);
    cyc("sw_wait", 0, 0, MWR);
    cyc("sw_rdy", 1, 0, MWR);

    // beq taken / not taken
    opcode = 7'b1100011;
    cyc("beq_t_fetch", 1, 1, F_RDY);
    cyc("beq_t_dec", 0, 1, DEC);
    cyc("beq_taken", 0, 1, BR_T);
    cyc("beq_n_fetch", 1, 0, F_RDY);
    cyc("beq_n_dec", 0, 0, DEC);
    cyc("beq_not", 0, 0, BR_N);

    // jal, addi, illegal
    opcode = 7'b1101111;
    cyc("jal_fetch", 1, 0, F_RDY);
    cyc("jal_dec", 0, 0, DEC);
    cyc("jal_exec", 1, 0, JALV);
    opcode = 7'b0010011;
    cyc("addi_fetch", 1, 0, F_RDY);
    cyc("addi_dec", 0, 0, DEC);
    cyc("addi_exec", 0, 0, EXI);
    cyc("addi_wb", 0, 0, AWB);
    opcode = 7'b1111111;
    cyc("ill_fetch", 1, 0, F_RDY);
    cyc("ill_dec", 0, 0, DEC);
    cyc("ill_trap", 0, 0, TRAPV);

    // FETCH timeout on cycle 16, then ready arriving on the would-be timeout cycle
    for (int i = 0; i < 15; i++) cyc("fetch_wait", 0, 0, F_WAIT);
    cyc("fetch_tmo", 0, 0, F_TMO);
    for (int i = 0; i < 15; i++) cyc("fetch_rewait", 0, 0, F_WAIT);
    opcode = 7'b0010011;
    cyc("fetch_rdy_at_tmo", 1, 0, F_RDY);
    cyc("post_tmo_dec", 0, 0, DEC);
    cyc("post_tmo_exec", 0, 0, EXI);
    cyc("post_tmo_wb", 0, 0, AWB);

    // store timeout in MEM_WR
    opcode = 7'b0100011;
    cyc("swt_fetch", 1, 0, F_RDY);
    cyc("swt_dec", 0, 0, DEC);
    cyc("swt_addr", 0, 0, MADDR);
    for (int i = 0; i < 15; i++) cyc("swt_wait", 0, 0, MWR);
    cyc("swt_tmo", 0, 0, MWR_TMO);
    cyc("swt_refetch", 1, 0, F_RDY);
    cyc("swr_dec", 0, 0, DEC);
    cyc("swr_addr", 0, 0, MADDR);
    cyc("swr_wait", 0, 0, MWR);

    // async reset mid MEM_WR wait: outputs must drop between clock edges
    mem_ready = 1'b0;
    #1;
    check("pre_rst_memwe", 32'(mem_we), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rst_async", 32'(obs), 32'(IDLE));
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc("post_rst_fetch", 0, 0, F_WAIT);
    opcode = 7'b0110011;
    cyc("post_rst_rdy", 1, 0, F_RDY);
    cyc("post_rst_dec", 0, 0, DEC);
    cyc("post_rst_exec", 0, 0, EXR);
    cyc("post_rst_wb", 0, 0, AWB);
    cyc("final_fetch", 0, 0, F_WAIT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
